pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
- Match sequencer for the two-player pong display datapath; owns the game flow (title, serve, rally, point, game over) and both scores.
- Consumes the per-frame refresh tick and ball-exit flags from the pixel datapath.
- Drives ball hold/reset/run controls, title enable, scores and the winner code back to the datapath and to the score overlay.

Parameters:
- WIN_SCORE, 7, points needed to win a match; legal range 1..15.
- SERVE_FRAMES, 60, frame ticks the ball is held at centre before a serve; legal range 1..255.
- POINT_FRAMES, 90, frame ticks of freeze after a point before the next serve or game over; legal range 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- frame_tick  input  1  one-cycle pulse per frame, start of vertical retrace
- start_btn  input  1  synchronised start/pause button, level
- miss_left  input  1  ball left edge passed x=0; paddle-1 player scores
- miss_right  input  1  ball right edge passed x=639; paddle-2 player scores
- game_state  output  3  current state encoding
- ball_reset  output  1  one-cycle pulse: datapath recentres ball and loads serve direction
- ball_run  output  1  high = datapath may advance ball position on frame ticks
- serve_dir  output  1  0 = serve toward paddle 1 (right), 1 = toward paddle 2 (left)
- show_title  output  1  enables title text overlay
- score1  output  4  paddle-1 player score, binary
- score2  output  4  paddle-2 player score, binary
- winner  output  2  00 none, 01 paddle 1, 10 paddle 2

Behaviour:
- Reset values:
  - game_state=IDLE; ball_reset=0; ball_run=0; serve_dir=0; show_title=1; score1=score2=0; winner=00.
  - Frame counter=0; start edge register=0.
- All outputs are registered. A state change takes effect the cycle after the sampled triggering input.
- State encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4, PAUSE=5 (PAUSE only with optional feature); 6–7 unused, treated as IDLE.
- Start edge: start_pe = start_btn & ~start_d, where start_d is registered every cycle. Only the rising edge is used; a held button acts once.
- Frame counter: 8-bit. Cleared on every state entry. Increments on each frame_tick while in SERVE or POINT. Frozen otherwise.
- IDLE:
  - show_title=1, ball_run=0.
  - start_pe: clear scores, winner=00, serve_dir=0, go to SERVE.
- SERVE:
  - ball_reset=1 in the first cycle game_state==SERVE only.
  - Ball held.
  - On the frame_tick that brings the count to SERVE_FRAMES: go to PLAY.
- PLAY:
  - ball_run=1.
  - miss_left only: score1+1, serve_dir=1, go to POINT.
  - miss_right only: score2+1, serve_dir=0, go to POINT.
  - Both in the same cycle: no score change, serve_dir unchanged, go to POINT (let).
- POINT:
  - ball_run=0.
  - On the frame_tick that brings the count to POINT_FRAMES:
    - score1==WIN_SCORE: winner=01, go to OVER.
    - else score2==WIN_SCORE: winner=10, go to OVER.
    - else go to SERVE.
- OVER:
  - ball_run=0; winner and scores held.
  - start_pe: go to IDLE. Scores are not cleared until the next IDLE start.
- Miss flags are ignored outside PLAY, including the exit cycle of PLAY. Start edges are ignored in SERVE and POINT.
- Scores saturate at WIN_SCORE and never wrap.
- frame_tick coincident with a state entry is not counted in the new state.
- Reset mid-game returns immediately to reset values.

Optional Feature:
- Macro: PONG_PAUSE_EN.
- Defined:
  - start_pe in PLAY goes to PAUSE. In PAUSE: ball_run=0, miss flags ignored, frame counter frozen, scores held.
  - start_pe in PAUSE returns to PLAY.
- Not defined: start_pe in PLAY is ignored, and encoding 5 is unreachable (treated as IDLE).
- The start_btn port exists in both builds.

Test Plan:
1. Reset, then start_btn pulse -> game_state 0→1 one cycle after the edge; ball_reset high exactly 1 cycle; show_title=0; after 60 frame_ticks game_state=2, ball_run=1.
2. In PLAY, assert miss_left 1 cycle -> score1=1, serve_dir=1, game_state=3; after 90 ticks game_state=1 with a ball_reset pulse.
3. miss_left and miss_right in the same cycle in PLAY -> scores unchanged, game_state=3; miss pulses during POINT/SERVE cause no score change.
4. Drive seven miss_right points -> after the 7th POINT delay game_state=4, winner=10, score2=7; start_btn held high for 100 cycles -> exactly one transition to IDLE; next start clears scores.
5. Assert reset mid-PLAY with score1=3 -> all outputs at reset values within the same cycle; start_btn held high through the reset release does not start a game.
6. PONG_PAUSE_EN build: start edge in PLAY -> state 5, ball_run=0, miss ignored; second edge -> state 2. Non-PONG_PAUSE_EN build: start edge in PLAY leaves state 2.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match sequencer for the two-player pong datapath.
// Walks title -> serve -> rally -> point -> game over, keeps both scores,
// and drives the ball hold/recentre/run controls and the score overlay.
// Optional build macro PONG_PAUSE_EN: a start edge during a rally pauses
// the game and a second start edge resumes it.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 7,   // 1..15
  parameter int SERVE_FRAMES = 60,  // 1..255
  parameter int POINT_FRAMES = 90   // 1..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic [2:0] game_state,
  output logic       ball_reset,
  output logic       ball_run,
  output logic       serve_dir,
  output logic       show_title,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4,
    PAUSE = 3'd5
  } state_t;

  localparam logic [3:0] WinScore   = 4'(WIN_SCORE);
  localparam logic [7:0] ServeLimit = 8'(SERVE_FRAMES);
  localparam logic [7:0] PointLimit = 8'(POINT_FRAMES);

  state_t     state;
  logic [7:0] frameCnt;
  logic [7:0] frameNext;
  logic       startD;
  logic       startArm;
  logic       startPe;
  logic       anyMiss;

  // startArm stays low for the first cycle after reset so a button that is
  // already held when reset releases is seen as a level, not a new press.
  assign startPe   = start_btn & ~startD & startArm;
  assign frameNext = frameCnt + 8'd1;
  assign anyMiss   = miss_left | miss_right;
  assign game_state = state;

  // Start button edge detector: history register updated every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      startD   <= 1'b0;
      startArm <= 1'b0;
    end else begin
      startD   <= start_btn;
      startArm <= 1'b1;
    end
  end

  // Game flow FSM; every output is a flop updated alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      frameCnt   <= 8'd0;
      ball_reset <= 1'b0;
      ball_run   <= 1'b0;
      serve_dir  <= 1'b0;
      show_title <= 1'b1;
      score1     <= 4'd0;
      score2     <= 4'd0;
      winner     <= 2'b00;
    end else begin
      // ball_reset is a single-cycle pulse on SERVE entry only
      ball_reset <= 1'b0;
      case (state)
        IDLE: begin
          if (startPe) begin
            score1     <= 4'd0;
            score2     <= 4'd0;
            winner     <= 2'b00;
            serve_dir  <= 1'b0;
            show_title <= 1'b0;
            ball_reset <= 1'b1;
            frameCnt   <= 8'd0;
            state      <= SERVE;
          end
        end

        SERVE: begin
          if (frame_tick) begin
            if (frameNext == ServeLimit) begin
              frameCnt <= 8'd0;
              ball_run <= 1'b1;
              state    <= PLAY;
            end else begin
              frameCnt <= frameNext;
            end
          end
        end

        PLAY: begin
          if (anyMiss) begin
            // a simultaneous double miss is a let: no score, direction kept
            if (miss_left && !miss_right) begin
              if (score1 < WinScore) score1 <= score1 + 4'd1;
              serve_dir <= 1'b1;
            end else if (miss_right && !miss_left) begin
              if (score2 < WinScore) score2 <= score2 + 4'd1;
              serve_dir <= 1'b0;
            end
            ball_run <= 1'b0;
            frameCnt <= 8'd0;
            state    <= POINT;
          end
`ifdef PONG_PAUSE_EN
          else if (startPe) begin
            ball_run <= 1'b0;
            frameCnt <= 8'd0;
            state    <= PAUSE;
          end
`endif
        end

        POINT: begin
          if (frame_tick) begin
            if (frameNext == PointLimit) begin
              frameCnt <= 8'd0;
              if (score1 == WinScore) begin
                winner <= 2'b01;
                state  <= OVER;
              end else if (score2 == WinScore) begin
                winner <= 2'b10;
                state  <= OVER;
              end else begin
                ball_reset <= 1'b1;
                state      <= SERVE;
              end
            end else begin
              frameCnt <= frameNext;
            end
          end
        end

        OVER: begin
          // scores and winner stay visible on the title screen
          if (startPe) begin
            show_title <= 1'b1;
            frameCnt   <= 8'd0;
            state      <= IDLE;
          end
        end

`ifdef PONG_PAUSE_EN
        PAUSE: begin
          if (startPe) begin
            ball_run <= 1'b1;
            frameCnt <= 8'd0;
            state    <= PLAY;
          end
        end
`endif

        default: begin
          // unused encodings fall back to the title screen
          ball_run   <= 1'b0;
          show_title <= 1'b1;
          frameCnt   <= 8'd0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed scenarios with spec-derived constants,
// then randomized traffic checked against a behavioural game model.
module tb_pong_game_ctrl;
  localparam int WIN = 7;
  localparam int SF  = 60;
  localparam int PF  = 90;
`ifdef PONG_PAUSE_EN
  localparam bit HAS_PAUSE = 1'b1;
`else
  localparam bit HAS_PAUSE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic [2:0] game_state;
  logic       ball_reset, ball_run, serve_dir, show_title;
  logic [3:0] score1, score2;
  logic [1:0] winner;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pong_game_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
    .miss_left(miss_left), .miss_right(miss_right), .game_state(game_state),
    .ball_reset(ball_reset), .ball_run(ball_run), .serve_dir(serve_dir),
    .show_title(show_title), .score1(score1), .score2(score2), .winner(winner)
  );

  // behavioural game model: state number, scores, frames elapsed in state
  int mState, mS1, mS2, mWin, mDir, mCnt;
  bit mStartD, mArm, mFirst;

  task automatic modelReset;
    mState = 0; mS1 = 0; mS2 = 0; mWin = 0; mDir = 0; mCnt = 0;
    mStartD = 0; mArm = 0; mFirst = 0;
  endtask

  task automatic modelStep(input bit ft, input bit sb, input bit ml, input bit mr);
    bit pe;
    int nxt;
    pe = sb && !mStartD && mArm;
    mStartD = sb;
    mArm = 1;
    nxt = mState;
    case (mState)
      1: if (ft) begin mCnt++; if (mCnt == SF) nxt = 2; end
      2: begin
        if (ml || mr) begin
          if (ml && !mr) begin mS1 = (mS1 + 1 > WIN) ? WIN : mS1 + 1; mDir = 1; end
          else if (mr && !ml) begin mS2 = (mS2 + 1 > WIN) ? WIN : mS2 + 1; mDir = 0; end
          nxt = 3;
        end else if (pe && HAS_PAUSE) nxt = 5;
      end
      3: if (ft) begin
        mCnt++;
        if (mCnt == PF) begin
          if (mS1 == WIN) begin mWin = 1; nxt = 4; end
          else if (mS2 == WIN) begin mWin = 2; nxt = 4; end
          else nxt = 1;
        end
      end
      4: if (pe) nxt = 0;
      5: if (pe) nxt = 2;
      default: if (pe) begin mS1 = 0; mS2 = 0; mWin = 0; mDir = 0; nxt = 1; end
    endcase
    mFirst = (nxt == 1) && (mState != 1);
    if (nxt != mState) mCnt = 0;
    mState = nxt;
  endtask

  // one clock of stimulus; the model advances on the same edge as the DUT
  task automatic step(input bit ft, input bit sb, input bit ml, input bit mr);
    @(negedge clk);
    frame_tick = ft; start_btn = sb; miss_left = ml; miss_right = mr;
    @(posedge clk);
    modelStep(ft, sb, ml, mr);
    #1;
  endtask

  task automatic runTicks(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset;
    @(negedge clk);
    reset = 1'b1;
    modelReset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    modelReset();
    @(negedge clk);
    total++;
    if ({game_state, ball_reset, ball_run, serve_dir, show_title, score1, score2, winner}
        !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0}) begin
      bad++;
      $display("FAIL reset_values got=%h want=%h",
        {game_state, ball_reset, ball_run, serve_dir, show_title, score1, score2, winner},
        {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0});
    end
    reset = 1'b0;
    step(0, 0, 0, 0);
  endtask

  task automatic test_serve;
    step(0, 1, 0, 0);
    total++;
    if ({game_state, ball_reset, show_title} !== {3'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL serve_entry got=%h want=%h", {game_state, ball_reset, show_title}, {3'd1, 1'b1, 1'b0});
    end
    step(0, 0, 0, 0);
    total++;
    if ({game_state, ball_reset} !== {3'd1, 1'b0}) begin
      bad++; $display("FAIL serve_pulse_len got=%h want=%h", {game_state, ball_reset}, {3'd1, 1'b0});
    end
    runTicks(SF - 1);
    total++;
    if ({game_state, ball_run} !== {3'd1, 1'b0}) begin
      bad++; $display("FAIL serve_hold got=%h want=%h", {game_state, ball_run}, {3'd1, 1'b0});
    end
    runTicks(1);
    total++;
    if ({game_state, ball_run} !== {3'd2, 1'b1}) begin
      bad++; $display("FAIL serve_to_play got=%h want=%h", {game_state, ball_run}, {3'd2, 1'b1});
    end
  endtask

  task automatic test_point;
    step(0, 0, 1, 0);
    total++;
    if ({game_state, score1, score2, serve_dir, ball_run} !== {3'd3, 4'd1, 4'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL point_left got=%h want=%h", {game_state, score1, score2, serve_dir, ball_run},
        {3'd3, 4'd1, 4'd0, 1'b1, 1'b0});
    end
    runTicks(PF - 1);
    total++;
    if (game_state !== 3'd3) begin
      bad++; $display("FAIL point_hold got=%0d want=3", game_state);
    end
    runTicks(1);
    total++;
    if ({game_state, ball_reset} !== {3'd1, 1'b1}) begin
      bad++; $display("FAIL point_to_serve got=%h want=%h", {game_state, ball_reset}, {3'd1, 1'b1});
    end
    runTicks(SF);
  endtask

  task automatic test_let;
    step(0, 0, 1, 1);
    total++;
    if ({game_state, score1, score2, serve_dir} !== {3'd3, 4'd1, 4'd0, 1'b1}) begin
      bad++; $display("FAIL let got=%h want=%h", {game_state, score1, score2, serve_dir}, {3'd3, 4'd1, 4'd0, 1'b1});
    end
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    runTicks(PF);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    total++;
    if ({game_state, score1, score2} !== {3'd1, 4'd1, 4'd0}) begin
      bad++; $display("FAIL miss_outside_play got=%h want=%h", {game_state, score1, score2}, {3'd1, 4'd1, 4'd0});
    end
    runTicks(SF);
  endtask

  task automatic test_game_over;
    int trans;
    logic [2:0] prev;
    for (int i = 0; i < WIN; i++) begin
      step(0, 0, 0, 1);
      runTicks(PF);
      if (i < WIN - 1) runTicks(SF);
    end
    total++;
    if ({game_state, winner, score2, score1} !== {3'd4, 2'b10, 4'd7, 4'd1}) begin
      bad++; $display("FAIL game_over got=%h want=%h", {game_state, winner, score2, score1}, {3'd4, 2'b10, 4'd7, 4'd1});
    end
    trans = 0;
    prev = game_state;
    repeat (100) begin
      step(0, 1, 0, 0);
      if (game_state !== prev) trans++;
      prev = game_state;
    end
    total++;
    if (trans !== 1 || game_state !== 3'd0 || score2 !== 4'd7 || show_title !== 1'b1) begin
      bad++; $display("FAIL held_start trans=%0d state=%0d score2=%0d title=%0d want 1/0/7/1",
        trans, game_state, score2, show_title);
    end
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    total++;
    if ({game_state, score1, score2, winner} !== {3'd1, 4'd0, 4'd0, 2'b00}) begin
      bad++; $display("FAIL restart_clear got=%h want=%h", {game_state, score1, score2, winner}, {3'd1, 4'd0, 4'd0, 2'b00});
    end
  endtask

  task automatic test_reset_mid;
    runTicks(SF);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      runTicks(PF);
      runTicks(SF);
    end
    total++;
    if ({game_state, score1} !== {3'd2, 4'd3}) begin
      bad++; $display("FAIL mid_setup got=%h want=%h", {game_state, score1}, {3'd2, 4'd3});
    end
    @(negedge clk);
    start_btn = 1'b1;
    reset = 1'b1;
    modelReset();
    #1;
    total++;
    if ({game_state, ball_reset, ball_run, serve_dir, show_title, score1, score2, winner}
        !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0}) begin
      bad++;
      $display("FAIL mid_reset got=%h want=%h",
        {game_state, ball_reset, ball_run, serve_dir, show_title, score1, score2, winner},
        {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) step(0, 1, 0, 0);
    total++;
    if (game_state !== 3'd0) begin
      bad++; $display("FAIL held_through_reset got=%0d want=0", game_state);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_pause;
    step(0, 1, 0, 0);
    runTicks(SF);
    step(0, 1, 0, 0);
    if (HAS_PAUSE) begin
      total++;
      if ({game_state, ball_run} !== {3'd5, 1'b0}) begin
        bad++; $display("FAIL pause_enter got=%h want=%h", {game_state, ball_run}, {3'd5, 1'b0});
      end
      step(0, 0, 1, 0);
      total++;
      if ({game_state, score1} !== {3'd5, 4'd0}) begin
        bad++; $display("FAIL pause_miss got=%h want=%h", {game_state, score1}, {3'd5, 4'd0});
      end
      step(0, 1, 0, 0);
      total++;
      if ({game_state, ball_run} !== {3'd2, 1'b1}) begin
        bad++; $display("FAIL pause_resume got=%h want=%h", {game_state, ball_run}, {3'd2, 1'b1});
      end
    end else begin
      step(0, 0, 0, 0);
      total++;
      if ({game_state, ball_run} !== {3'd2, 1'b1}) begin
        bad++; $display("FAIL no_pause got=%h want=%h", {game_state, ball_run}, {3'd2, 1'b1});
      end
    end
  endtask

  task automatic test_random;
    bit ft, sb, ml, mr;
    doReset();
    for (int c = 0; c < 12000; c++) begin
      ft = ($urandom % 3) == 0;
      sb = ($urandom % 30) == 0;
      ml = ($urandom % 25) == 0;
      mr = ($urandom % 25) == 0;
      step(ft, sb, ml, mr);
      total++;
      if (game_state !== 3'(mState)) begin
        bad++; $display("FAIL rnd_state cyc=%0d got=%0d want=%0d", c, game_state, mState);
      end
      total++;
      if ({ball_reset, ball_run, show_title, serve_dir} !==
          {mFirst, mState == 2, mState == 0, 1'(mDir)}) begin
        bad++; $display("FAIL rnd_ctrl cyc=%0d got=%b want=%b", c, {ball_reset, ball_run, show_title, serve_dir},
          {mFirst, mState == 2, mState == 0, 1'(mDir)});
      end
      total++;
      if ({score1, score2, winner} !== {4'(mS1), 4'(mS2), 2'(mWin)}) begin
        bad++; $display("FAIL rnd_score cyc=%0d got=%h want=%h", c, {score1, score2, winner},
          {4'(mS1), 4'(mS2), 2'(mWin)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_point();
    test_let();
    test_game_over();
    test_reset_mid();
    test_pause();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
